// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall, flush and forwarding control for a 5-stage pipeline.
// It sequences load-use stalls, EX-resolved redirects and data-memory waits, and
// watches memory waits with a sticky watchdog flag.
// Optional build macro: HAZCTRL_PERF_EN builds the saturating performance counters.
// Without it the counter ports are tied to zero.
module pipeline_hazard_ctrl #(
  parameter int WAIT_W      = 8,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rt,
  input  logic [4:0]  ex_rs,
  input  logic [4:0]  ex_rt,
  input  logic        idex_memread,
  input  logic [4:0]  idex_waddr,
  input  logic        exmem_wen,
  input  logic        memwb_wen,
  input  logic [4:0]  exmem_waddr,
  input  logic [4:0]  memwb_waddr,
  input  logic        ex_redirect,
  input  logic        dmem_busy,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        idex_write,
  output logic        exmem_write,
  output logic        memwb_write,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        pc_redirect,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic        mem_timeout,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt,
  output logic [15:0] wait_cnt_total
);

  typedef enum logic {RUN = 1'b0, WAIT = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                mem_timeout_q, mem_timeout_d;
  logic                lu;

  // Forwarding selects for both EX operands; EX/MEM wins over MEM/WB.
  logic [4:0] fwd_src [2];
  logic [1:0] fwd_sel [2];
  assign fwd_src[0] = ex_rs;
  assign fwd_src[1] = ex_rt;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      // Per-operand forwarding priority mux, forced to the register file in reset.
      always_comb begin
        fwd_sel[gi] = 2'b00;
        if (rst) begin
          if (exmem_wen && exmem_waddr != 5'd0 && exmem_waddr == fwd_src[gi])
            fwd_sel[gi] = 2'b10;
          else if (memwb_wen && memwb_waddr != 5'd0 && memwb_waddr == fwd_src[gi])
            fwd_sel[gi] = 2'b01;
        end
      end
    end
  endgenerate

  assign fwd_a = fwd_sel[0];
  assign fwd_b = fwd_sel[1];

  assign lu = idex_memread && (idex_waddr != 5'd0) &&
              ((idex_waddr == id_rs) || (id_uses_rt && (idex_waddr == id_rt)));

  // Pipeline control decode. A cycle with dmem_busy freezes everything in either
  // state; once busy drops, WAIT decodes exactly like RUN, so the frozen ID/EX
  // stages re-present any redirect or load-use on that same cycle.
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_write  = 1'b1;
    exmem_write = 1'b1;
    memwb_write = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    pc_redirect = 1'b0;
    if (!rst) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (dmem_busy) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_write = 1'b0;
      memwb_write = 1'b0;
    end else if (ex_redirect) begin
      // The ID instruction is wrong-path, so a coincident load-use is dropped.
      pc_redirect = 1'b1;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
    end else if (lu) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_flush = 1'b1;
    end
  end

  // Next state, wait counter and watchdog. The watchdog compares against the
  // count including the current busy cycle, so it rises right after the
  // MEM_TIMEOUT-th busy cycle.
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    case (state_q)
      RUN: begin
        if (dmem_busy) begin
          state_d    = WAIT;
          wait_cnt_d = WAIT_W'(1);
        end
      end
      default: begin
        if (dmem_busy) begin
          if (wait_cnt_q != {WAIT_W{1'b1}})
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end else begin
          state_d = RUN;
        end
      end
    endcase
    mem_timeout_d = mem_timeout_q ||
                    (dmem_busy && (wait_cnt_d == WAIT_W'(MEM_TIMEOUT)));
  end

  // FSM state, wait counter and sticky watchdog registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= RUN;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  assign mem_timeout = mem_timeout_q;

`ifdef HAZCTRL_PERF_EN
  logic [15:0] stall_cnt_q, flush_cnt_q, wait_total_q;
  logic        lu_stall;

  // A load-use stall is issued only when neither busy nor redirect outrank it.
  assign lu_stall = rst && !dmem_busy && !ex_redirect && lu;

  // Saturating event counters, one increment per edge at most.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
      wait_total_q <= '0;
    end else begin
      if (lu_stall && stall_cnt_q != 16'hFFFF)
        stall_cnt_q <= stall_cnt_q + 16'd1;
      if (pc_redirect && flush_cnt_q != 16'hFFFF)
        flush_cnt_q <= flush_cnt_q + 16'd1;
      if (dmem_busy && wait_total_q != 16'hFFFF)
        wait_total_q <= wait_total_q + 16'd1;
    end
  end

  assign stall_cnt      = stall_cnt_q;
  assign flush_cnt      = flush_cnt_q;
  assign wait_cnt_total = wait_total_q;
`else
  assign stall_cnt      = 16'd0;
  assign flush_cnt      = 16'd0;
  assign wait_cnt_total = 16'd0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with a scoreboard of expected control
// vectors. Counter expectations follow the HAZCTRL_PERF_EN build macro.
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs, id_rt, ex_rs, ex_rt, idex_waddr, exmem_waddr, memwb_waddr;
  logic        id_uses_rt, idex_memread, exmem_wen, memwb_wen, ex_redirect, dmem_busy;
  logic        pc_write, ifid_write, idex_write, exmem_write, memwb_write;
  logic        ifid_flush, idex_flush, pc_redirect, mem_timeout;
  logic [1:0]  fwd_a, fwd_b;
  logic [15:0] stall_cnt, flush_cnt, wait_cnt_total;

  int n_chk = 0;
  int n_err = 0;

`ifdef HAZCTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // {pc_w, ifid_w, idex_w, exmem_w, memwb_w, ifid_fl, idex_fl, redir, fwd_a, fwd_b}
  localparam logic [11:0] C_NORMAL = 12'b11111_000_0000;
  localparam logic [11:0] C_STALL  = 12'b00111_010_0000;
  localparam logic [11:0] C_REDIR  = 12'b11111_111_0000;
  localparam logic [11:0] C_FREEZE = 12'b00000_000_0000;
  localparam logic [11:0] C_RESET  = 12'b11111_110_0000;

  typedef struct {
    string       tag;
    logic [11:0] ctrl;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.WAIT_W(8), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_rs(ex_rs), .ex_rt(ex_rt),
    .idex_memread(idex_memread), .idex_waddr(idex_waddr),
    .exmem_wen(exmem_wen), .memwb_wen(memwb_wen),
    .exmem_waddr(exmem_waddr), .memwb_waddr(memwb_waddr),
    .ex_redirect(ex_redirect), .dmem_busy(dmem_busy),
    .pc_write(pc_write), .ifid_write(ifid_write), .idex_write(idex_write),
    .exmem_write(exmem_write), .memwb_write(memwb_write),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .pc_redirect(pc_redirect),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_timeout(mem_timeout),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .wait_cnt_total(wait_cnt_total)
  );

  function automatic logic [11:0] obs_ctrl();
    return {pc_write, ifid_write, idex_write, exmem_write, memwb_write,
            ifid_flush, idex_flush, pc_redirect, fwd_a, fwd_b};
  endfunction

  function automatic logic [15:0] pv(input int v);
    return PERF ? 16'(v) : 16'd0;
  endfunction

  // Pop the oldest expectation and compare it with the live control outputs.
  task automatic check_ctrl();
    exp_t        e;
    logic [11:0] o;
    if (sb.size() == 0) begin
      n_chk++;
      n_err++;
      $error("FAIL scoreboard_empty observed=none expected=entry");
      return;
    end
    e = sb.pop_front();
    o = obs_ctrl();
    n_chk++;
    $display("step %-14s ctrl=%b", e.tag, o);
    assert (o === e.ctrl) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", e.tag, o, e.ctrl);
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] o, input logic [15:0] x);
    n_chk++;
    assert (o === x) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, x);
    end
  endtask

  // Called at posedge+1 with inputs set: check on the falling edge, then
  // advance through the next rising edge.
  task automatic step(input string tag, input logic [11:0] exp_ctrl);
    exp_t e;
    e.tag  = tag;
    e.ctrl = exp_ctrl;
    sb.push_back(e);
    @(negedge clk);
    check_ctrl();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_rs = 0; id_rt = 0; id_uses_rt = 0; ex_rs = 0; ex_rt = 0;
    idex_memread = 0; idex_waddr = 0; exmem_wen = 0; memwb_wen = 0;
    exmem_waddr = 0; memwb_waddr = 0; ex_redirect = 0; dmem_busy = 0;
  endtask

  task automatic pulse_reset();
    clear_inputs();
    rst = 1'b0;
    #2;
    rst = 1'b1;
  endtask

  initial begin
    exp_t e;
    clear_inputs();
    rst = 1'b0;
    // Reset outputs, with inputs that would otherwise forward and stall.
    ex_rs = 5; ex_rt = 5; exmem_wen = 1; exmem_waddr = 5;
    idex_memread = 1; idex_waddr = 8; id_rs = 8; dmem_busy = 1;
    @(posedge clk); #1;
    step("reset_ctrl", C_RESET);
    chk("reset_timeout", 16'(mem_timeout), 16'd0);
    chk("reset_stall", stall_cnt, 16'd0);
    chk("reset_wait", wait_cnt_total, 16'd0);
    clear_inputs();
    rst = 1'b1;

    // Load-use on rs, then bubble released.
    idex_memread = 1; idex_waddr = 8; id_rs = 8;
    step("lu_rs", C_STALL);
    idex_memread = 0;
    step("lu_release", C_NORMAL);
    chk("lu_stall_cnt", stall_cnt, pv(1));
    chk("lu_flush_cnt", flush_cnt, pv(0));
    // rt only counts when the ID instruction reads rt.
    idex_memread = 1; id_rs = 3; id_rt = 8; id_uses_rt = 0;
    step("lu_rt_unused", C_NORMAL);
    id_uses_rt = 1;
    step("lu_rt_used", C_STALL);
    // A load to r0 never stalls.
    idex_waddr = 0; id_rs = 0; id_rt = 0;
    step("lu_r0", C_NORMAL);
    chk("lu_stall_cnt2", stall_cnt, pv(2));
    clear_inputs();

    // Forwarding priority.
    ex_rs = 5; ex_rt = 5; exmem_waddr = 5; memwb_waddr = 5; exmem_wen = 1; memwb_wen = 1;
    step("fwd_exmem", C_NORMAL | 12'b1010);
    exmem_wen = 0;
    step("fwd_memwb", C_NORMAL | 12'b0101);
    exmem_wen = 1; exmem_waddr = 0; memwb_waddr = 0; ex_rs = 0; ex_rt = 0;
    step("fwd_r0", C_NORMAL);
    ex_rs = 5; ex_rt = 6; exmem_waddr = 5; memwb_waddr = 6;
    step("fwd_mixed", C_NORMAL | 12'b1001);
    clear_inputs();

    // Redirect outranks a simultaneous load-use.
    pulse_reset();
    ex_redirect = 1; idex_memread = 1; idex_waddr = 8; id_rs = 8;
    step("redir_lu", C_REDIR);
    clear_inputs();
    step("redir_after", C_NORMAL);
    chk("redir_flush_cnt", flush_cnt, pv(1));
    chk("redir_stall_cnt", stall_cnt, pv(0));

    // Memory wait with a pending redirect and load-use.
    pulse_reset();
    dmem_busy = 1; ex_redirect = 1; idex_memread = 1; idex_waddr = 8; id_rs = 8;
    for (int i = 1; i <= 3; i++) step($sformatf("wait_busy%0d", i), C_FREEZE);
    dmem_busy = 0;
    step("wait_exit", C_REDIR);
    ex_redirect = 0;
    step("wait_lu_replay", C_STALL);
    clear_inputs();
    step("wait_normal", C_NORMAL);
    chk("wait_total", wait_cnt_total, pv(3));
    chk("wait_flush_cnt", flush_cnt, pv(1));
    chk("wait_stall_cnt", stall_cnt, pv(1));
    chk("wait_no_timeout", 16'(mem_timeout), 16'd0);

    // Watchdog with MEM_TIMEOUT = 4.
    pulse_reset();
    dmem_busy = 1;
    for (int i = 1; i <= 10; i++) begin
      step($sformatf("wdog_busy%0d", i), C_FREEZE);
      chk($sformatf("wdog_flag%0d", i), 16'(mem_timeout), (i >= 4) ? 16'd1 : 16'd0);
    end
    dmem_busy = 0;
    step("wdog_exit", C_NORMAL);
    chk("wdog_sticky", 16'(mem_timeout), 16'd1);
    chk("wdog_total", wait_cnt_total, pv(10));
    // Reset while in WAIT.
    dmem_busy = 1;
    step("wdog_reenter", C_FREEZE);
    rst = 1'b0;
    #1;
    e.tag = "wdog_rst_ctrl";
    e.ctrl = C_RESET;
    sb.push_back(e);
    check_ctrl();
    chk("wdog_rst_clear", 16'(mem_timeout), 16'd0);
    chk("wdog_rst_total", wait_cnt_total, 16'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    dmem_busy = 0;
    step("wdog_run", C_NORMAL);
    // Back in RUN: a single busy cycle loads the counter to 1, no timeout.
    dmem_busy = 1;
    step("wdog_busy_again", C_FREEZE);
    chk("wdog_no_refire", 16'(mem_timeout), 16'd0);
    dmem_busy = 0;
    step("wdog_done", C_NORMAL);

    chk("sb_drained", 16'(sb.size()), 16'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
